// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with M/W forwarding and ALU operand select.
// Revision: 1.0
`default_nettype none

module id_ex_stage #(
  parameter int         WIDTH       = 32,
  parameter logic [5:0] BUBBLE_TYPE = 6'b000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             hold,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_pc,
  input  logic [WIDTH-1:0] d_rs_val,
  input  logic [WIDTH-1:0] d_rt_val,
  input  logic [4:0]       d_rs_addr,
  input  logic [4:0]       d_rt_addr,
  input  logic [15:0]      d_imm16,
  input  logic [4:0]       d_shamt,
  input  logic             d_ext_op,
  input  logic             d_src_sel,
  input  logic             d_shamt_sel,
  input  logic [5:0]       d_alu_type,
  input  logic [4:0]       d_wr_addr,
  input  logic             d_reg_we,
  input  logic [4:0]       m_wr_addr,
  input  logic             m_reg_we,
  input  logic [WIDTH-1:0] m_fwd_data,
  input  logic [4:0]       w_wr_addr,
  input  logic             w_reg_we,
  input  logic [WIDTH-1:0] w_fwd_data,
  output logic [WIDTH-1:0] e_alu_in1,
  output logic [WIDTH-1:0] e_alu_in2,
  output logic [5:0]       e_alu_type,
  output logic [WIDTH-1:0] e_store_data,
  output logic [WIDTH-1:0] e_link,
  output logic [WIDTH-1:0] e_pc,
  output logic [4:0]       e_wr_addr,
  output logic             e_reg_we,
  output logic             e_valid
);

  logic             r_valid;
  logic             r_reg_we;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_rs_val;
  logic [WIDTH-1:0] r_rt_val;
  logic [4:0]       r_rs_addr;
  logic [4:0]       r_rt_addr;
  logic [15:0]      r_imm16;
  logic [4:0]       r_shamt;
  logic             r_ext_op;
  logic             r_src_sel;
  logic             r_shamt_sel;
  logic [5:0]       r_type;
  logic [4:0]       r_wr_addr;

  logic             w_update;
  logic             w_load;
  logic [WIDTH-1:0] w_rs_fwd;
  logic [WIDTH-1:0] w_rt_fwd;
  logic [WIDTH-1:0] w_ext_imm;

  // flush overrides hold; otherwise hold freezes E even when stall asks for a bubble
  assign w_update = flush | ~hold;
  assign w_load   = ~flush & ~stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid     <= 1'b0;
      r_reg_we    <= 1'b0;
      r_pc        <= '0;
      r_rs_val    <= '0;
      r_rt_val    <= '0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_imm16     <= '0;
      r_shamt     <= '0;
      r_ext_op    <= 1'b0;
      r_src_sel   <= 1'b0;
      r_shamt_sel <= 1'b0;
      r_type      <= BUBBLE_TYPE;
      r_wr_addr   <= '0;
    end else if (w_update) begin
      r_valid     <= w_load & d_valid;
      r_reg_we    <= w_load & d_valid & d_reg_we;
      r_pc        <= w_load ? d_pc        : '0;
      r_rs_val    <= w_load ? d_rs_val    : '0;
      r_rt_val    <= w_load ? d_rt_val    : '0;
      r_rs_addr   <= w_load ? d_rs_addr   : '0;
      r_rt_addr   <= w_load ? d_rt_addr   : '0;
      r_imm16     <= w_load ? d_imm16     : '0;
      r_shamt     <= w_load ? d_shamt     : '0;
      r_ext_op    <= w_load & d_ext_op;
      r_src_sel   <= w_load & d_src_sel;
      r_shamt_sel <= w_load & d_shamt_sel;
      r_type      <= w_load ? d_alu_type  : BUBBLE_TYPE;
      r_wr_addr   <= w_load ? d_wr_addr   : '0;
    end
  end

  // M is younger than W, so it wins; $0 always reads the captured value
  always_comb begin
    w_rs_fwd = r_rs_val;
    if (r_rs_addr != 5'd0) begin
      if (m_reg_we && (m_wr_addr == r_rs_addr))      w_rs_fwd = m_fwd_data;
      else if (w_reg_we && (w_wr_addr == r_rs_addr)) w_rs_fwd = w_fwd_data;
    end
  end

  always_comb begin
    w_rt_fwd = r_rt_val;
    if (r_rt_addr != 5'd0) begin
      if (m_reg_we && (m_wr_addr == r_rt_addr))      w_rt_fwd = m_fwd_data;
      else if (w_reg_we && (w_wr_addr == r_rt_addr)) w_rt_fwd = w_fwd_data;
    end
  end

  assign w_ext_imm = r_ext_op ? {{(WIDTH-16){r_imm16[15]}}, r_imm16}
                              : {{(WIDTH-16){1'b0}}, r_imm16};

  assign e_alu_in1    = r_shamt_sel ? {{(WIDTH-5){1'b0}}, r_shamt} : w_rs_fwd;
  assign e_alu_in2    = r_src_sel ? w_ext_imm : w_rt_fwd;
  assign e_alu_type   = r_type;
  assign e_store_data = w_rt_fwd;
  assign e_link       = r_pc + WIDTH'(8);
  assign e_pc         = r_pc;
  assign e_wr_addr    = r_wr_addr;
  assign e_reg_we     = r_reg_we;
  assign e_valid      = r_valid;

endmodule

`default_nettype wire
